// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Purpose  : Shared types and helpers for the FIR async FIFO write front end:
//            Gray-to-binary conversion, pointer width and skid-count encodings.
// Revision : 1.0  initial release
// ============================================================================
package fifo_pkg;

  // Widest pointer the Gray converter handles; narrower pointers are
  // zero-extended on the way in and cast back down on the way out.
  localparam int c_GRAY_MAX_W = 32;

  // Pointers carry one extra wrap bit above the address.
  function automatic int ptr_width(input int addr_size);
    return addr_size + 1;
  endfunction

  // Skid buffer occupancy.
  typedef enum logic [1:0] {
    CNT_EMPTY = 2'd0,
    CNT_ONE   = 2'd1,
    CNT_TWO   = 2'd2
  } skid_cnt_e;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above
  // it. Leading zeros from zero-extension leave the result unchanged.
  function automatic logic [c_GRAY_MAX_W-1:0] gray2bin(input logic [c_GRAY_MAX_W-1:0] gray);
    logic [c_GRAY_MAX_W-1:0] bin;
    bin[c_GRAY_MAX_W-1] = gray[c_GRAY_MAX_W-1];
    for (int i = c_GRAY_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : fifo_skid_buf
// Purpose  : Two-entry FIFO-ordered skid buffer between the producer
//            handshake and the FIFO write strobe. Ready is registered.
// Revision : 1.0  initial release
// ============================================================================
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_full,
  output logic                  o_pop,
  output logic [DATA_WIDTH-1:0] o_data
);

  skid_cnt_e             r_cnt;
  skid_cnt_e             w_cnt_nxt;
  logic                  r_ready;
  logic                  r_head;
  logic [DATA_WIDTH-1:0] r_mem [2];
  logic                  w_accept;
  logic                  w_pop;
  logic                  w_tail;

  assign w_accept = i_valid & r_ready;
  // Pop gating mirrors the write-pointer stage so each strobe moves it once.
  assign w_pop    = (r_cnt != CNT_EMPTY) & ~i_full;
  // Tail slot is head+count; count is never 2 when an accept happens.
  assign w_tail   = r_head ^ (r_cnt == CNT_ONE);

  // Next occupancy from accept/pop; simultaneous accept and pop holds count.
  always_comb begin
    w_cnt_nxt = r_cnt;
    case (r_cnt)
      CNT_EMPTY: if (w_accept) w_cnt_nxt = CNT_ONE;
      CNT_ONE: begin
        if (w_accept && !w_pop)      w_cnt_nxt = CNT_TWO;
        else if (!w_accept && w_pop) w_cnt_nxt = CNT_EMPTY;
      end
      CNT_TWO:   if (w_pop) w_cnt_nxt = CNT_ONE;
      default:   w_cnt_nxt = CNT_EMPTY;
    endcase
  end

  // Occupancy, registered ready and head pointer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= CNT_EMPTY;
      r_ready <= 1'b0;
      r_head  <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_ready <= (w_cnt_nxt != CNT_TWO);
      r_head  <= r_head ^ w_pop;
    end
  end

  // Sample storage; an accepted sample lands in the tail slot.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
    end else if (w_accept) begin
      r_mem[w_tail] <= i_data;
    end
  end

  assign o_ready = r_ready;
  assign o_pop   = w_pop;
  assign o_data  = r_mem[r_head];

endmodule
`default_nettype wire

// File: rtl/fifo_wr_frontend.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_frontend
// Purpose  : Write-side front end of the FIR async FIFO: producer handshake
//            via skid buffer, gated write strobe, fill level, almost-full and
//            optional producer stall counter.
// Options  : FIFO_WR_STALL_CNT_EN builds the saturating stall counter;
//            otherwise o_stall_cnt is tied to zero.
// Revision : 1.0  initial release
// ============================================================================
module fifo_wr_frontend
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_SIZE    = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                  i_wr_clk,
  input  logic                  i_wrrst_n,
  input  logic [DATA_WIDTH-1:0] i_s_data,
  input  logic                  i_s_valid,
  output logic                  o_s_ready,
  output logic                  o_wr_inc,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  input  logic                  i_wr_full,
  input  logic [ADDR_SIZE:0]    i_gray_wrptr,
  input  logic [ADDR_SIZE:0]    i_gray_q2_rdptr,
  output logic [ADDR_SIZE:0]    o_wr_level,
  output logic                  o_almost_full,
  output logic [15:0]           o_stall_cnt
);

  localparam int                 c_PTR_W        = ptr_width(ADDR_SIZE);
  localparam logic [c_PTR_W-1:0] c_AFULL_THRESH = c_PTR_W'(AFULL_THRESH);

  logic               w_ready;
  logic [c_PTR_W-1:0] w_wbin;
  logic [c_PTR_W-1:0] w_rbin;
  logic [c_PTR_W-1:0] w_level;
  logic [c_PTR_W-1:0] r_level;
  logic               r_almost_full;

  fifo_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .i_clk   (i_wr_clk),
    .i_rst_n (i_wrrst_n),
    .i_data  (i_s_data),
    .i_valid (i_s_valid),
    .o_ready (w_ready),
    .i_full  (i_wr_full),
    .o_pop   (o_wr_inc),
    .o_data  (o_wr_data)
  );

  assign o_s_ready = w_ready;

  // Modulo subtraction of the binary pointers absorbs wrap-around; the
  // synchronised read pointer lags, so the level can only be overstated.
  assign w_wbin  = c_PTR_W'(gray2bin(c_GRAY_MAX_W'(i_gray_wrptr)));
  assign w_rbin  = c_PTR_W'(gray2bin(c_GRAY_MAX_W'(i_gray_q2_rdptr)));
  assign w_level = w_wbin - w_rbin;

  // Register fill level and almost-full from the current pointers.
  always_ff @(posedge i_wr_clk or negedge i_wrrst_n) begin
    if (!i_wrrst_n) begin
      r_level       <= '0;
      r_almost_full <= 1'b0;
    end else begin
      r_level       <= w_level;
      r_almost_full <= (w_level >= c_AFULL_THRESH);
    end
  end

  assign o_wr_level    = r_level;
  assign o_almost_full = r_almost_full;

`ifdef FIFO_WR_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Count cycles the producer is held off; saturate rather than wrap.
  always_ff @(posedge i_wr_clk or negedge i_wrrst_n) begin
    if (!i_wrrst_n) begin
      r_stall_cnt <= 16'd0;
    end else if (i_s_valid && !w_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`else
  assign o_stall_cnt = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_frontend.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_frontend
// Purpose  : Self-checking bench for fifo_wr_frontend against a queue-based
//            reference model and a table of pointer/level vectors.
// Revision : 1.0  initial release
// ============================================================================
module tb_fifo_wr_frontend;

  localparam int DW = 16;
  localparam int AS = 4;
  localparam int PW = AS + 1;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic          wr_inc;
  logic [DW-1:0] wr_data;
  logic          wr_full;
  logic [PW-1:0] gwr;
  logic [PW-1:0] grd;
  logic [PW-1:0] wr_level;
  logic          almost_full;
  logic [15:0]   stall_cnt;

  fifo_wr_frontend #(
    .DATA_WIDTH   (DW),
    .ADDR_SIZE    (AS),
    .AFULL_THRESH (12)
  ) dut (
    .i_wr_clk        (clk),
    .i_wrrst_n       (rst_n),
    .i_s_data        (s_data),
    .i_s_valid       (s_valid),
    .o_s_ready       (s_ready),
    .o_wr_inc        (wr_inc),
    .o_wr_data       (wr_data),
    .i_wr_full       (wr_full),
    .i_gray_wrptr    (gwr),
    .i_gray_q2_rdptr (grd),
    .o_wr_level      (wr_level),
    .o_almost_full   (almost_full),
    .o_stall_cnt     (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: buffered samples in order, ready flag, stall count.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] wr_log[$];
  bit            m_ready;
  int            m_stall;
  bit            last_acc;
  bit            last_inc;
  logic [DW-1:0] last_data;

  typedef struct {
    int wbin;
    int rbin;
    int lvl;
    bit af;
  } lvl_vec_t;

  lvl_vec_t lv[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] bin2gray(input int b);
    logic [PW-1:0] v;
    v = PW'(b);
    return v ^ (v >> 1);
  endfunction

  // One clock: compare at negedge, advance the model for the coming edge.
  task automatic step();
    bit acc;
    bit pop;
    @(negedge clk);
    pop = (mq.size() != 0) && !wr_full;
    chk("s_ready", {31'd0, s_ready}, {31'd0, m_ready});
    chk("wr_inc", {31'd0, wr_inc}, {31'd0, pop});
    if (wr_inc === 1'b1) begin
      wr_log.push_back(wr_data);
      if (mq.size() != 0) chk("wr_data", {16'd0, wr_data}, {16'd0, mq[0]});
    end
    chk("stall_cnt", {16'd0, stall_cnt}, m_stall);
    last_inc  = wr_inc;
    last_data = wr_data;
    acc = s_valid && m_ready;
`ifdef FIFO_WR_STALL_CNT_EN
    if (s_valid && !m_ready && m_stall != 32'hFFFF) m_stall++;
`endif
    if (pop) void'(mq.pop_front());
    if (acc) mq.push_back(s_data);
    m_ready  = (mq.size() != 2);
    last_acc = acc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] aseq[3];
    int            idx;
    int            cyc;
    int            log0;
    int            prev_lvl;

    lv[0] = '{2, 30, 4, 1'b0};
    lv[1] = '{28, 16, 12, 1'b1};
    lv[2] = '{5, 21, 16, 1'b1};
    lv[3] = '{0, 0, 0, 1'b0};
    lv[4] = '{11, 0, 11, 1'b0};
    lv[5] = '{3, 24, 11, 1'b0};
    lv[6] = '{13, 1, 12, 1'b1};
    lv[7] = '{31, 20, 11, 1'b0};
    lv[8] = '{7, 29, 10, 1'b0};
    lv[9] = '{16, 0, 16, 1'b1};

    m_ready = 1'b0;
    m_stall = 0;
    rst_n   = 1'b0;
    s_data  = '0;
    s_valid = 1'b0;
    wr_full = 1'b0;
    gwr     = '0;
    grd     = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_wr_inc", {31'd0, wr_inc}, 32'd0);
    chk("rst_wr_data", {16'd0, wr_data}, 32'd0);
    chk("rst_wr_level", {27'd0, wr_level}, 32'd0);
    chk("rst_almost_full", {31'd0, almost_full}, 32'd0);
    chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    chk("ready_after_release", {31'd0, s_ready}, 32'd1);
    chk("level_after_release", {27'd0, wr_level}, 32'd0);

    // Level / almost-full vectors, including one-cycle latency
    prev_lvl = 0;
    for (int i = 0; i < 10; i++) begin
      gwr = bin2gray(lv[i].wbin);
      grd = bin2gray(lv[i].rbin);
      @(negedge clk);
      chk($sformatf("level_latency[%0d]", i), {27'd0, wr_level}, prev_lvl);
      @(posedge clk);
      #1;
      chk($sformatf("level[%0d]", i), {27'd0, wr_level}, lv[i].lvl);
      chk($sformatf("afull[%0d]", i), {31'd0, almost_full}, {31'd0, lv[i].af});
      prev_lvl = lv[i].lvl;
    end
    gwr = '0;
    grd = '0;

    // Single sample on an empty FIFO
    s_valid = 1'b1;
    s_data  = 16'h1234;
    step();
    chk("single_accept", {31'd0, last_acc}, 32'd1);
    s_valid = 1'b0;
    step();
    chk("single_inc", {31'd0, last_inc}, 32'd1);
    chk("single_data", {16'd0, last_data}, 32'h1234);
    step();
    chk("single_drained", {31'd0, last_inc}, 32'd0);

    // Full back-pressure: two accepted, third held until full releases
    aseq[0] = 16'hA001;
    aseq[1] = 16'hA002;
    aseq[2] = 16'hA003;
    wr_full = 1'b1;
    log0    = wr_log.size();
    idx     = 0;
    for (int c = 0; c < 6; c++) begin
      s_valid = (idx < 3);
      s_data  = aseq[idx < 3 ? idx : 2];
      step();
      if (last_acc) idx++;
    end
    chk("full_accepted", idx, 32'd2);
    chk("full_ready_low", {31'd0, s_ready}, 32'd0);
    chk("full_no_write", wr_log.size() - log0, 32'd0);
    wr_full = 1'b0;
    cyc = 0;
    while ((idx < 3 || mq.size() != 0) && cyc < 50) begin
      s_valid = (idx < 3);
      s_data  = aseq[idx < 3 ? idx : 2];
      step();
      if (last_acc) idx++;
      cyc++;
    end
    s_valid = 1'b0;
    chk("full_seq_timeout", {31'd0, (cyc >= 50)}, 32'd0);
    chk("full_write_count", wr_log.size() - log0, 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (log0 + i < wr_log.size())
        chk($sformatf("full_order[%0d]", i), {16'd0, wr_log[log0+i]}, {16'd0, aseq[i]});
    end

    // Continuous stream of 100 samples with no back-pressure
    log0 = wr_log.size();
    for (int c = 0; c < 100; c++) begin
      s_valid = 1'b1;
      s_data  = 16'h5000 + 16'(c);
      step();
      if (c > 0) chk("stream_count_one", mq.size(), 32'd1);
    end
    s_valid = 1'b0;
    step();
    step();
    chk("stream_writes", wr_log.size() - log0, 32'd100);

    // Randomised traffic against the model
    for (int c = 0; c < 400; c++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = 16'($urandom);
      wr_full = ($urandom_range(0, 3) == 0);
      step();
    end
    s_valid = 1'b0;
    wr_full = 1'b0;
    repeat (4) step();
    chk("random_drained", mq.size(), 32'd0);

`ifdef FIFO_WR_STALL_CNT_EN
    // Long stall to reach saturation
    wr_full = 1'b1;
    s_valid = 1'b1;
    for (int c = 0; c < 70000; c++) step();
    chk("stall_saturated", {16'd0, stall_cnt}, 32'hFFFF);
    wr_full = 1'b0;
    s_valid = 1'b0;
`else
    chk("stall_tied_zero", {16'd0, stall_cnt}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
